fetch_unit: RTL

- Fetch stage that sits directly upstream of the 256 x 30-bit instruction memory. It drives that memory's `pc`/`fetch_en` and shares its bidirectional 30-bit instruction bus.
- Two jobs:
  - Program load: writes words into memory over the shared bus before execution.
  - Run: streams fetched instructions to decode through a valid/ready handshake with a 2-entry buffer, and supports branch redirect and halt detection.

---
 rtl/fetch_unit.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Fetch stage in front of a 256 x 30-bit instruction memory: loads a program over the
// shared bus, then streams fetched words to decode through a 2-entry buffer.
module fetch_unit #(
  parameter logic [7:0]  START_PC  = 8'h00,
  parameter logic [29:0] HALT_WORD = 30'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        load_valid,
  input  logic [29:0] load_data,
  output logic        load_ready,
  output logic [7:0]  pc,
  output logic        fetch_en,
  inout  wire  [29:0] instr_bus,
  input  logic        branch_taken,
  input  logic [7:0]  branch_target,
  output logic [29:0] instr_out,
  output logic [7:0]  instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        halted,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  load_ptr_q;
  logic [7:0]  pc_q;
  logic        inflight_q;
  logic [7:0]  inflight_pc_q;
  logic [29:0] buf_word_q [2];
  logic [7:0]  buf_pc_q   [2];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  count_q, count_d;

  logic        idle_or_load;
  logic        running;
  logic        load_write;
  logic        pop;
  logic        branch;
  logic        hit_halt;
  logic        push;
  logic        issue;
  logic [1:0]  occ_after_pop;
  logic [1:0]  committed;

  assign idle_or_load = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign running      = (state_q == S_RUN) || (state_q == S_DRAIN);

  // start wins over a pending load word, so no write happens in the start cycle.
  assign load_write = (state_q == S_LOAD) && load_valid && !start;

  // Decode handshake: a word moves at a rising edge when instr_valid && instr_ready
  // were both high before it; instr_out/instr_pc stay put while valid waits for ready.
  assign pop    = instr_valid && instr_ready;
  assign branch = running && branch_taken;

  // inflight_q means the memory is presenting the word addressed one edge ago.
  assign hit_halt = inflight_q && (instr_bus == HALT_WORD);
  assign push     = inflight_q && !hit_halt && !branch;

  assign occ_after_pop = count_q - {1'b0, pop};
  assign committed     = occ_after_pop + {1'b0, inflight_q};
  assign issue         = (state_q == S_RUN) && !branch && !hit_halt && (committed < 2'd2);

  assign count_d = branch ? 2'd0 : (count_q + {1'b0, push} - {1'b0, pop});

  assign fetch_en    = !load_write;
  assign load_ready  = load_write;
  assign pc          = idle_or_load ? load_ptr_q : pc_q;
  assign instr_bus   = fetch_en ? {30{1'bz}} : load_data;
  assign instr_valid = running && (count_q != 2'd0);
  assign instr_out   = buf_word_q[rd_ptr_q];
  assign instr_pc    = buf_pc_q[rd_ptr_q];
  assign halted      = (state_q == S_HALT);
  assign state_dbg   = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start)           state_d = S_RUN;
        else if (load_valid) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (start)            state_d = S_RUN;
        else if (!load_valid) state_d = S_IDLE;
      end
      S_RUN: begin
        if (branch)        state_d = S_RUN;
        else if (hit_halt) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (branch)                state_d = S_RUN;
        else if (count_d == 2'd0)  state_d = S_HALT;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_ptr_q    <= '0;
      pc_q          <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= '0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_word_q[i] <= '0;
        buf_pc_q[i]   <= '0;
      end
    end else begin
      if (idle_or_load && start) begin
        load_ptr_q <= '0;
      end else if (load_write) begin
        load_ptr_q <= load_ptr_q + 8'd1;
      end

      if (idle_or_load && start) begin
        pc_q <= START_PC;
      end else if (branch) begin
        pc_q <= branch_target;
      end else if (issue) begin
        pc_q <= pc_q + 8'd1;
      end

      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= pc_q;
      end

      count_q <= count_d;
      // A redirect discards whatever is buffered after this cycle's handshake.
      if (branch) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        if (push) begin
          buf_word_q[wr_ptr_q] <= instr_bus;
          buf_pc_q[wr_ptr_q]   <= inflight_pc_q;
          wr_ptr_q             <= ~wr_ptr_q;
        end
        if (pop) begin
          rd_ptr_q <= ~rd_ptr_q;
        end
      end
    end
  end

endmodule
